bmp_stream_parser: RTL and testbench

//  Consumes a byte stream holding a complete 24-bpp uncompressed BMP file and parses the 54-byte

---
 rtl/bmp_stream_parser.sv | 196 +++++++++++++++++++
 tb/tb_bmp_stream_parser.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_parser.sv
// Streaming reader for 24-bpp uncompressed BMP files: parses the 54-byte header and emits {R,G,B}
// pixels with row/frame markers. Define BMP_HDR_CHECK_EN to reject unsupported headers via o_err.
`timescale 1ns/1ps
module bmp_stream_parser #(
   parameter int unsigned MAX_W = 4096,
   parameter int unsigned MAX_H = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_byte,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [23:0] o_pix,
   output logic        o_pix_valid,
   input  logic        i_pix_ready,
   output logic        o_sol,
   output logic        o_eol,
   output logic        o_eof,
   output logic [15:0] o_width,
   output logic [15:0] o_height,
   output logic        o_hdr_done,
   output logic        o_err,
   output logic        o_busy
);

   typedef enum logic [2:0] {IDLE, HDR, SKIP, PIX, OUT, PAD, DONE, ERR} state_t;
   state_t state, stateNext;

   logic [5:0]  hdrCnt;
   logic [31:0] skipCnt;
   logic [15:0] colCnt, rowCnt;
   logic [1:0]  byteIdx, padCnt, padLen;
   logic        solQ, eolQ, eofQ, hdrDone;
   logic [31:0] offBits;
   logic [15:0] width, height;
   logic [7:0]  blue, green;
   logic        take, hdrLast, hdrBad, skipNeeded, skipLast, emptyImg, padLast, pixLast;

`ifdef BMP_HDR_CHECK_EN
   logic [15:0]        bfType, planes, bitCount, widthHi, heightHi;
   logic [31:0]        compression, widthFull;
   logic signed [31:0] heightFull;

   assign widthFull  = {widthHi, width};
   assign heightFull = signed'({heightHi, height});
   assign hdrBad = (bfType != 16'h4D42) || (planes != 16'd1) || (bitCount != 16'd24) ||
                   (compression != 32'd0) || (offBits < 32'd54) ||
                   (widthFull == 32'd0) || (widthFull > MAX_W) ||
                   (heightFull <= 0) || ($unsigned(heightFull) > MAX_H);
   assign o_err  = (state == ERR);
`else
   assign hdrBad = 1'b0;
   assign o_err  = 1'b0;
`endif

   // Handshake and per-state terminal conditions; i_start overrides any byte transfer
   assign o_ready    = !i_start && (state inside {HDR, SKIP, PIX, PAD});
   assign take       = i_valid && o_ready;
   assign hdrLast    = (state == HDR) && take && (hdrCnt == 6'd53);
   assign skipNeeded = offBits > 32'd54;
   assign skipLast   = take && (skipCnt == offBits - 32'd55);
   assign emptyImg   = (width == 16'd0) || (height == 16'd0);
   assign padLen     = width[1:0];
   assign padLast    = take && (padCnt == padLen - 2'd1);
   assign pixLast    = take && (byteIdx == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (i_start) begin
         stateNext = HDR;
      end else begin
         case (state)
            HDR: if (hdrLast) begin
               if (hdrBad)          stateNext = ERR;
               else if (skipNeeded) stateNext = SKIP;
               else if (emptyImg)   stateNext = DONE;
               else                 stateNext = PIX;
            end
            SKIP: if (skipLast) stateNext = emptyImg ? DONE : PIX;
            PIX:  if (pixLast)  stateNext = OUT;
            OUT:  if (i_pix_ready) begin
               if (!eolQ)              stateNext = PIX;
               else if (padLen != 0)   stateNext = PAD;
               else if (eofQ)          stateNext = DONE;
               else                    stateNext = PIX;
            end
            PAD:  if (padLast) stateNext = eofQ ? DONE : PIX;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdrCnt  <= '0;
         skipCnt <= '0;
         colCnt  <= '0;
         rowCnt  <= '0;
         byteIdx <= '0;
         padCnt  <= '0;
         solQ    <= 1'b0;
         eolQ    <= 1'b0;
         eofQ    <= 1'b0;
         hdrDone <= 1'b0;
         o_pix   <= '0;
      end else if (i_start) begin
         hdrCnt  <= '0;
         skipCnt <= '0;
         colCnt  <= '0;
         rowCnt  <= '0;
         byteIdx <= '0;
         padCnt  <= '0;
         solQ    <= 1'b0;
         eolQ    <= 1'b0;
         eofQ    <= 1'b0;
         hdrDone <= 1'b0;
      end else begin
         if ((state == HDR) && take) hdrCnt <= hdrCnt + 6'd1;
         if (hdrLast && !hdrBad) hdrDone <= 1'b1;
         if ((state == SKIP) && take) skipCnt <= skipCnt + 32'd1;
         if (state == PIX && take) begin
            if (byteIdx == 2'd2) begin
               byteIdx <= 2'd0;
               o_pix   <= {i_byte, green, blue};
               solQ    <= (colCnt == 16'd0);
               eolQ    <= (colCnt == width - 16'd1);
               eofQ    <= (colCnt == width - 16'd1) && (rowCnt == height - 16'd1);
            end else begin
               byteIdx <= byteIdx + 2'd1;
            end
         end
         if ((state == OUT) && i_pix_ready) begin
            if (eolQ) begin
               colCnt <= 16'd0;
               rowCnt <= rowCnt + 16'd1;
            end else begin
               colCnt <= colCnt + 16'd1;
            end
         end
         if ((state == PAD) && take) padCnt <= padLast ? 2'd0 : padCnt + 2'd1;
      end
   end

   // Header fields and partial pixel bytes are pure data: captured on transfer, never reset
   always_ff @(posedge clk) begin
      if ((state == HDR) && take) begin
         case (hdrCnt)
            6'd10: offBits[7:0]   <= i_byte;
            6'd11: offBits[15:8]  <= i_byte;
            6'd12: offBits[23:16] <= i_byte;
            6'd13: offBits[31:24] <= i_byte;
            6'd18: width[7:0]     <= i_byte;
            6'd19: width[15:8]    <= i_byte;
            6'd22: height[7:0]    <= i_byte;
            6'd23: height[15:8]   <= i_byte;
`ifdef BMP_HDR_CHECK_EN
            6'd0:  bfType[7:0]        <= i_byte;
            6'd1:  bfType[15:8]       <= i_byte;
            6'd20: widthHi[7:0]       <= i_byte;
            6'd21: widthHi[15:8]      <= i_byte;
            6'd24: heightHi[7:0]      <= i_byte;
            6'd25: heightHi[15:8]     <= i_byte;
            6'd26: planes[7:0]        <= i_byte;
            6'd27: planes[15:8]       <= i_byte;
            6'd28: bitCount[7:0]      <= i_byte;
            6'd29: bitCount[15:8]     <= i_byte;
            6'd30: compression[7:0]   <= i_byte;
            6'd31: compression[15:8]  <= i_byte;
            6'd32: compression[23:16] <= i_byte;
            6'd33: compression[31:24] <= i_byte;
`endif
            default: ;
         endcase
      end
      if ((state == PIX) && take) begin
         if (byteIdx == 2'd0) blue  <= i_byte;
         if (byteIdx == 2'd1) green <= i_byte;
      end
   end

   assign o_pix_valid = (state == OUT);
   assign o_sol       = solQ && o_pix_valid;
   assign o_eol       = eolQ && o_pix_valid;
   assign o_eof       = eofQ && o_pix_valid;
   assign o_hdr_done  = hdrDone;
   assign o_width     = hdrDone ? width  : 16'd0;
   assign o_height    = hdrDone ? height : 16'd0;
   assign o_busy      = !(state inside {IDLE, DONE, ERR});

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed bench for bmp_stream_parser: builds BMP byte streams, drives them through the
// byte/pixel handshakes and compares emitted pixels, markers and status against hand values.
`timescale 1ns/1ps
module tb_bmp_stream_parser;
   logic        clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_valid = 1'b0, i_pix_ready = 1'b0;
   logic [7:0]  i_byte = 8'h00;
   logic        o_ready, o_pix_valid, o_sol, o_eol, o_eof, o_hdr_done, o_err, o_busy;
   logic [23:0] o_pix;
   logic [15:0] o_width, o_height;

   int          passCnt = 0, totalCnt = 0;
   logic [7:0]  byteQ[$];
   logic [26:0] pixQ[$];
   int          consumed, stableErr, readyErr;
   bit          timedOut;

   always #5 clk = ~clk;

   bmp_stream_parser dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_byte(i_byte), .i_valid(i_valid),
      .o_ready(o_ready), .o_pix(o_pix), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
      .o_sol(o_sol), .o_eol(o_eol), .o_eof(o_eof), .o_width(o_width), .o_height(o_height),
      .o_hdr_done(o_hdr_done), .o_err(o_err), .o_busy(o_busy)
   );

   task automatic clearRun();
      byteQ.delete();
      pixQ.delete();
      consumed  = 0;
      stableErr = 0;
      readyErr  = 0;
   endtask

   task automatic pushHdr(input logic [7:0] t0, input logic [7:0] t1, input int off,
                          input int w, input int h);
      logic [7:0] hb[54];
      for (int i = 0; i < 54; i++) hb[i] = 8'h00;
      hb[0] = t0;
      hb[1] = t1;
      for (int k = 0; k < 4; k++) begin
         hb[10+k] = 8'(off >> (8*k));
         hb[18+k] = 8'(w >> (8*k));
         hb[22+k] = 8'(h >> (8*k));
      end
      hb[14] = 8'd40;
      hb[26] = 8'd1;
      hb[28] = 8'd24;
      for (int i = 0; i < 54; i++) byteQ.push_back(hb[i]);
   endtask

   task automatic startFile();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Streams byteQ into the DUT; pixels are accepted after 'hold' waiting cycles.
   task automatic runEngine(input int hold, input int budget, input bit stopOnPending);
      int         waitCnt = 0;
      logic [23:0] heldPix = '0;
      timedOut = 1'b1;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if ((stopOnPending && byteQ.size() == 0 && o_pix_valid) || !o_busy) begin
            timedOut = 1'b0;
            break;
         end
         i_valid     = (byteQ.size() > 0);
         i_byte      = (byteQ.size() > 0) ? byteQ[0] : 8'h00;
         i_pix_ready = o_pix_valid && (waitCnt >= hold);
         #1;
         if (i_valid && o_ready) begin
            void'(byteQ.pop_front());
            consumed++;
         end
         if (o_pix_valid) begin
            if (waitCnt == 0) heldPix = o_pix;
            else if (o_pix !== heldPix) stableErr++;
            if (o_ready) readyErr++;
            if (i_pix_ready) begin
               pixQ.push_back({o_pix, o_sol, o_eol, o_eof});
               waitCnt = 0;
            end else begin
               waitCnt++;
            end
         end
      end
      i_valid     = 1'b0;
      i_pix_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      totalCnt++;
      if ({o_ready, o_pix_valid, o_busy, o_hdr_done, o_err, o_pix, o_width, o_height} !== '0)
         $display("FAIL reset_outputs: got %h required 0",
                  {o_ready, o_pix_valid, o_busy, o_hdr_done, o_err, o_pix, o_width, o_height});
      else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      i_valid = 1'b1;
      repeat (3) @(negedge clk);
      totalCnt++;
      if ({o_ready, o_busy} !== 2'b00) $display("FAIL reset_idle: got ready/busy %b required 00", {o_ready, o_busy});
      else passCnt++;
      i_valid = 1'b0;
   endtask

   task automatic test_2x2();
      logic [26:0] exp[4];
      exp[0] = {24'h030201, 3'b100};
      exp[1] = {24'h060504, 3'b010};
      exp[2] = {24'h090807, 3'b100};
      exp[3] = {24'h0C0B0A, 3'b011};
      clearRun();
      pushHdr(8'h42, 8'h4D, 54, 2, 2);
      for (int i = 1; i <= 6; i++) byteQ.push_back(8'(i));
      byteQ.push_back(8'h00); byteQ.push_back(8'h00);
      for (int i = 7; i <= 12; i++) byteQ.push_back(8'(i));
      byteQ.push_back(8'h00); byteQ.push_back(8'h00);
      byteQ.push_back(8'hFF); byteQ.push_back(8'hFF);
      startFile();
      runEngine(0, 400, 1'b0);
      totalCnt++;
      if (timedOut) $display("FAIL 2x2_timeout: got timeout required DONE"); else passCnt++;
      totalCnt++;
      if (pixQ.size() != 4) $display("FAIL 2x2_count: got %0d required 4", pixQ.size()); else passCnt++;
      for (int i = 0; i < 4; i++) begin
         totalCnt++;
         if (i >= pixQ.size() || pixQ[i] !== exp[i])
            $display("FAIL 2x2_pix%0d: got %h required %h", i, (i < pixQ.size()) ? pixQ[i] : 27'h0, exp[i]);
         else passCnt++;
      end
      totalCnt++;
      if (consumed != 70 || byteQ.size() != 2)
         $display("FAIL 2x2_consumed: got %0d left %0d required 70 left 2", consumed, byteQ.size());
      else passCnt++;
      totalCnt++;
      if ({o_width, o_height} !== {16'd2, 16'd2})
         $display("FAIL 2x2_dims: got %0d x %0d required 2 x 2", o_width, o_height);
      else passCnt++;
      totalCnt++;
      if ({o_hdr_done, o_busy, o_ready, o_err} !== 4'b1000)
         $display("FAIL 2x2_status: got %b required 1000", {o_hdr_done, o_busy, o_ready, o_err});
      else passCnt++;
   endtask

   task automatic test_backpressure();
      logic [26:0] exp[4];
      exp[0] = {24'h121110, 3'b100};
      exp[1] = {24'h222120, 3'b000};
      exp[2] = {24'h323130, 3'b000};
      exp[3] = {24'h424140, 3'b011};
      clearRun();
      pushHdr(8'h42, 8'h4D, 54, 4, 1);
      for (int p = 1; p <= 4; p++)
         for (int c = 0; c < 3; c++) byteQ.push_back(8'(16*p + c));
      startFile();
      runEngine(5, 600, 1'b0);
      totalCnt++;
      if (timedOut || pixQ.size() != 4)
         $display("FAIL bp_count: got %0d pixels timeout %0d required 4 timeout 0", pixQ.size(), timedOut);
      else passCnt++;
      for (int i = 0; i < 4; i++) begin
         totalCnt++;
         if (i >= pixQ.size() || pixQ[i] !== exp[i])
            $display("FAIL bp_pix%0d: got %h required %h", i, (i < pixQ.size()) ? pixQ[i] : 27'h0, exp[i]);
         else passCnt++;
      end
      totalCnt++;
      if (stableErr != 0 || readyErr != 0)
         $display("FAIL bp_hold: got unstable %0d ready_while_held %0d required 0 0", stableErr, readyErr);
      else passCnt++;
      totalCnt++;
      if (consumed != 66) $display("FAIL bp_consumed: got %0d required 66", consumed); else passCnt++;
   endtask

   task automatic test_offset();
      clearRun();
      pushHdr(8'h42, 8'h4D, 58, 1, 1);
      repeat (4) byteQ.push_back(8'hEE);
      byteQ.push_back(8'hAA); byteQ.push_back(8'hBB); byteQ.push_back(8'hCC);
      byteQ.push_back(8'h00); byteQ.push_back(8'h55);
      startFile();
      runEngine(0, 400, 1'b0);
      totalCnt++;
      if (timedOut || pixQ.size() != 1 || pixQ[0] !== {24'hCCBBAA, 3'b111})
         $display("FAIL offset_pix: got %h (n=%0d) required %h", (pixQ.size() > 0) ? pixQ[0] : 27'h0,
                  pixQ.size(), {24'hCCBBAA, 3'b111});
      else passCnt++;
      totalCnt++;
      if (consumed != 62) $display("FAIL offset_consumed: got %0d required 62", consumed); else passCnt++;
   endtask

   task automatic test_bad_magic();
      clearRun();
      pushHdr(8'h4D, 8'h42, 54, 2, 2);
      for (int i = 0; i < 16; i++) byteQ.push_back(8'(i + 1));
      startFile();
      runEngine(0, 400, 1'b0);
      totalCnt++;
      if (timedOut) $display("FAIL magic_timeout: got timeout required stop"); else passCnt++;
`ifdef BMP_HDR_CHECK_EN
      totalCnt++;
      if ({o_err, o_ready, o_busy, o_hdr_done} !== 4'b1000)
         $display("FAIL magic_status: got %b required 1000", {o_err, o_ready, o_busy, o_hdr_done});
      else passCnt++;
      totalCnt++;
      if (pixQ.size() != 0 || consumed != 54)
         $display("FAIL magic_consume: got %0d pixels %0d bytes required 0 pixels 54 bytes", pixQ.size(), consumed);
      else passCnt++;
`else
      totalCnt++;
      if (o_err !== 1'b0) $display("FAIL magic_err: got %b required 0", o_err); else passCnt++;
      totalCnt++;
      if (pixQ.size() != 4 || consumed != 70)
         $display("FAIL magic_consume: got %0d pixels %0d bytes required 4 pixels 70 bytes", pixQ.size(), consumed);
      else passCnt++;
`endif
   endtask

   task automatic test_restart();
      clearRun();
      pushHdr(8'h42, 8'h4D, 54, 2, 2);
      for (int i = 1; i <= 6; i++) byteQ.push_back(8'(i));
      byteQ.push_back(8'h00); byteQ.push_back(8'h00);
      byteQ.push_back(8'h07); byteQ.push_back(8'h08); byteQ.push_back(8'h09);
      startFile();
      runEngine(0, 400, 1'b1);
      totalCnt++;
      if (timedOut || o_pix_valid !== 1'b1 || o_pix !== 24'h090807)
         $display("FAIL restart_pending: got valid %b pix %h required 1 090807", o_pix_valid, o_pix);
      else passCnt++;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      totalCnt++;
      if ({o_pix_valid, o_hdr_done, o_busy} !== 3'b001)
         $display("FAIL restart_drop: got %b required 001", {o_pix_valid, o_hdr_done, o_busy});
      else passCnt++;
      @(negedge clk);
      i_start = 1'b0;
      clearRun();
      pushHdr(8'h42, 8'h4D, 54, 2, 2);
      for (int i = 1; i <= 6; i++) byteQ.push_back(8'(8'h20 + i));
      byteQ.push_back(8'h00); byteQ.push_back(8'h00);
      for (int i = 7; i <= 12; i++) byteQ.push_back(8'(8'h20 + i));
      byteQ.push_back(8'h00); byteQ.push_back(8'h00);
      runEngine(0, 400, 1'b0);
      totalCnt++;
      if (timedOut || pixQ.size() != 4 || consumed != 70)
         $display("FAIL restart_reparse: got %0d pixels %0d bytes required 4 pixels 70 bytes", pixQ.size(), consumed);
      else passCnt++;
      totalCnt++;
      if (pixQ.size() < 4 || pixQ[0] !== {24'h232221, 3'b100} || pixQ[3] !== {24'h2C2B2A, 3'b011})
         $display("FAIL restart_pix: got %h %h required %h %h", (pixQ.size() > 0) ? pixQ[0] : 27'h0,
                  (pixQ.size() > 3) ? pixQ[3] : 27'h0, {24'h232221, 3'b100}, {24'h2C2B2A, 3'b011});
      else passCnt++;
   endtask

   task automatic test_async_reset();
      clearRun();
      pushHdr(8'h42, 8'h4D, 54, 1, 1);
      byteQ.push_back(8'h61); byteQ.push_back(8'h62); byteQ.push_back(8'h63);
      startFile();
      runEngine(0, 400, 1'b1);
      totalCnt++;
      if (timedOut || o_pix_valid !== 1'b1 || o_pix !== 24'h636261)
         $display("FAIL areset_pending: got valid %b pix %h required 1 636261", o_pix_valid, o_pix);
      else passCnt++;
      #2 rst_n = 1'b0;
      #1;
      totalCnt++;
      if ({o_ready, o_pix_valid, o_sol, o_eol, o_eof, o_busy, o_hdr_done, o_err, o_pix, o_width, o_height} !== '0)
         $display("FAIL areset_outputs: got %h required 0",
                  {o_ready, o_pix_valid, o_sol, o_eol, o_eof, o_busy, o_hdr_done, o_err, o_pix, o_width, o_height});
      else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      i_valid = 1'b1;
      i_byte = 8'h42;
      repeat (3) @(negedge clk);
      totalCnt++;
      if ({o_ready, o_busy} !== 2'b00) $display("FAIL areset_idle: got ready/busy %b required 00", {o_ready, o_busy});
      else passCnt++;
      i_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_2x2();
      test_backpressure();
      test_offset();
      test_bad_magic();
      test_restart();
      test_async_reset();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
